// File: rtl/order_manager.sv
// order_manager: owns the customer order slots and the two serving windows.
// Orders spawn and age on game-second ticks. A full bowl on a window is scored
// against the most urgent order, and a clear_space pulse removes that bowl.
// All state changes on the falling edge of vsync. Reset is asynchronous.
//
// clear_space protocol: this is a fire-and-forget request with no ready
// return. clear_space[w] is high for exactly one vsync cycle per accepted
// delivery and is never 2'b11. After a pulse, window w ignores its cell for
// one more cycle so the action stage has time to remove the bowl.
module order_manager #(
  parameter int NUM_ORDERS     = 3,
  parameter int FRAMES_PER_SEC = 60,
  parameter int ORDER_SEC      = 40,
  parameter int SPAWN_SEC      = 15,
  parameter int BASE_POINTS    = 20,
  parameter int MISS_PENALTY   = 10
) (
  input  logic                         vsync,
  input  logic                         reset,
  input  logic [2:0]                   game_state,
  input  logic [7:0][12:0][3:0]        object_grid,
  output logic [1:0]                   clear_space,
  output logic [9:0]                   score,
  output logic [NUM_ORDERS-1:0]        order_active,
  output logic [NUM_ORDERS-1:0][5:0]   order_time,
  output logic [7:0]                   orders_served,
  output logic [7:0]                   orders_missed,
  output logic [3:0]                   win_state,
  output logic [5:0]                   spawn_count
);

  localparam logic [3:0]  G_BOWL_FULL  = 4'd4;
  localparam logic [2:0]  GS_START     = 3'd1;
  localparam logic [2:0]  GS_PLAY      = 3'd2;
  localparam int          SEC_W        = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(FRAMES_PER_SEC - 1);
  localparam logic [5:0]  SPAWN_RELOAD = 6'(SPAWN_SEC - 1);
  localparam logic [5:0]  ORDER_INIT   = 6'(ORDER_SEC);
  localparam logic [10:0] BASE_W       = 11'(BASE_POINTS);
  localparam logic [10:0] PEN_W        = 11'(MISS_PENALTY);
  localparam logic [10:0] SCORE_MAX    = 11'd999;

  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_CLEAR = 2'd1,
    W_WAIT  = 2'd2
  } win_t;

  logic                       play;
  logic                       start;
  logic [SEC_W-1:0]           sec_q;
  logic [SEC_W-1:0]           sec_d;
  logic [5:0]                 spawn_q;
  logic [5:0]                 spawn_d;
  win_t                       win_q [2];
  win_t                       win_d [2];
  logic [1:0]                 cell_full;
  logic [1:0]                 want;
  logic [1:0]                 detect;
  logic                       any_active;
  logic                       tick;
  logic                       spawn_now;
  logic                       deliver;
  logic                       tgt_found;
  logic                       free_found;
  logic [NUM_ORDERS-1:0]      tgt_sel;
  logic [NUM_ORDERS-1:0]      spawn_sel;
  logic [5:0]                 tgt_time;
  logic [NUM_ORDERS-1:0]      active_d;
  logic [NUM_ORDERS-1:0][5:0] time_d;
  logic [2:0]                 miss_cnt;
  logic [10:0]                pen;
  logic [10:0]                sum;
  logic [10:0]                capped;
  logic [9:0]                 score_d;
  logic [7:0]                 served_d;
  logic [8:0]                 missed_sum;
  logic [7:0]                 missed_d;
  logic                       grid_unused;

  // Only the two window cells matter here; other cells belong to other stages.
  assign grid_unused = ^object_grid;

  assign play        = (game_state == GS_PLAY);
  assign start       = (game_state == GS_START);
  assign any_active  = |order_active;
  assign tick        = play && (sec_q == SEC_LAST);
  assign spawn_now   = tick && (spawn_q == 6'd0);
  assign deliver     = |detect;
  assign clear_space = {win_q[1] == W_CLEAR, win_q[0] == W_CLEAR};
  assign win_state   = {win_q[1], win_q[0]};
  assign spawn_count = spawn_q;

  // Frame and spawn countdowns advance only in PLAY.
  always_comb begin
    sec_d   = sec_q;
    spawn_d = spawn_q;
    if (play) begin
      sec_d = (sec_q == SEC_LAST) ? '0 : sec_q + 1'b1;
    end
    if (tick) begin
      spawn_d = (spawn_q == 6'd0) ? SPAWN_RELOAD : spawn_q - 6'd1;
    end
  end

  // Window detection with fixed priority: window 0 beats window 1.
  always_comb begin
    cell_full[0] = (object_grid[4][12] == G_BOWL_FULL);
    cell_full[1] = (object_grid[5][12] == G_BOWL_FULL);
    for (int w = 0; w < 2; w++) begin
      want[w] = play && any_active && cell_full[w] && (win_q[w] == W_IDLE);
    end
    detect[0] = want[0];
    detect[1] = want[1] && !want[0];
  end

  // Window FSM next state. A pulse always finishes, even if PLAY was left.
  always_comb begin
    for (int w = 0; w < 2; w++) begin
      win_d[w] = win_q[w];
      if (start) begin
        win_d[w] = W_IDLE;
      end else begin
        case (win_q[w])
          W_IDLE:  if (detect[w]) win_d[w] = W_CLEAR;
          W_CLEAR: win_d[w] = W_WAIT;
          W_WAIT:  if (play) win_d[w] = W_IDLE;
          default: win_d[w] = W_IDLE;
        endcase
      end
    end
  end

  // Pick the delivery target: the most urgent order, lowest index on a tie.
  always_comb begin
    tgt_sel   = '0;
    tgt_time  = 6'd0;
    tgt_found = 1'b0;
    for (int i = 0; i < NUM_ORDERS; i++) begin
      if (order_active[i] && (!tgt_found || (order_time[i] < tgt_time))) begin
        tgt_sel    = '0;
        tgt_sel[i] = 1'b1;
        tgt_time   = order_time[i];
        tgt_found  = 1'b1;
      end
    end
  end

  // Pick the spawn slot: the lowest slot that is free before this edge.
  always_comb begin
    spawn_sel  = '0;
    free_found = 1'b0;
    for (int i = 0; i < NUM_ORDERS; i++) begin
      if (!order_active[i] && !free_found) begin
        spawn_sel[i] = 1'b1;
        free_found   = 1'b1;
      end
    end
  end

  // Per-slot update: a delivery beats an expiry on the same edge.
  always_comb begin
    active_d = order_active;
    time_d   = order_time;
    miss_cnt = 3'd0;
    pen      = 11'd0;
    for (int i = 0; i < NUM_ORDERS; i++) begin
      if (order_active[i]) begin
        if (deliver && tgt_sel[i]) begin
          active_d[i] = 1'b0;
          time_d[i]   = 6'd0;
        end else if (tick && (order_time[i] != 6'd0)) begin
          time_d[i] = order_time[i] - 6'd1;
          if (order_time[i] == 6'd1) begin
            active_d[i] = 1'b0;
            miss_cnt    = miss_cnt + 3'd1;
            pen         = pen + PEN_W;
          end
        end
      end else if (spawn_now && spawn_sel[i]) begin
        active_d[i] = 1'b1;
        time_d[i]   = ORDER_INIT;
      end
    end
  end

  // Score and counters: add the delivery, cap, then subtract penalties.
  always_comb begin
    sum        = {1'b0, score} + (deliver ? (BASE_W + {5'd0, tgt_time}) : 11'd0);
    capped     = (sum > SCORE_MAX) ? SCORE_MAX : sum;
    score_d    = (capped > pen) ? 10'(capped - pen) : 10'd0;
    served_d   = (deliver && (orders_served != 8'hFF)) ? orders_served + 8'd1 : orders_served;
    missed_sum = {1'b0, orders_missed} + {6'd0, miss_cnt};
    missed_d   = (missed_sum > 9'd255) ? 8'hFF : missed_sum[7:0];
  end

  // Game state registers: cleared by reset or START, frozen outside PLAY.
  always_ff @(negedge vsync or posedge reset) begin
    if (reset) begin
      sec_q         <= '0;
      spawn_q       <= 6'd0;
      score         <= 10'd0;
      order_active  <= '0;
      order_time    <= '0;
      orders_served <= 8'd0;
      orders_missed <= 8'd0;
    end else if (start) begin
      sec_q         <= '0;
      spawn_q       <= 6'd0;
      score         <= 10'd0;
      order_active  <= '0;
      order_time    <= '0;
      orders_served <= 8'd0;
      orders_missed <= 8'd0;
    end else if (play) begin
      sec_q         <= sec_d;
      spawn_q       <= spawn_d;
      score         <= score_d;
      order_active  <= active_d;
      order_time    <= time_d;
      orders_served <= served_d;
      orders_missed <= missed_d;
    end
  end

  // Window FSM state registers.
  always_ff @(negedge vsync or posedge reset) begin
    if (reset) begin
      win_q[0] <= W_IDLE;
      win_q[1] <= W_IDLE;
    end else begin
      win_q[0] <= win_d[0];
      win_q[1] <= win_d[1];
    end
  end

endmodule

// File: tb/tb_order_manager.sv
// tb_order_manager: drives three game runs (spawn timing, deliveries and
// arbitration, expiry, pause freeze, reset mid-pulse) and checks the results
// against hand-derived values. clear_space pulses are scoreboarded.
module tb_order_manager;

  localparam int N = 3;
  localparam logic [2:0] GS_WELCOME = 3'd0;
  localparam logic [2:0] GS_START   = 3'd1;
  localparam logic [2:0] GS_PLAY    = 3'd2;
  localparam logic [2:0] GS_PAUSE   = 3'd3;

  logic                 vsync = 1'b1;
  logic                 reset;
  logic [2:0]           game_state;
  logic [7:0][12:0][3:0] object_grid;
  logic [1:0]           clear_space;
  logic [9:0]           score;
  logic [N-1:0]         order_active;
  logic [N-1:0][5:0]    order_time;
  logic [7:0]           orders_served;
  logic [7:0]           orders_missed;
  logic [3:0]           win_state;
  logic [5:0]           spawn_count;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];

  order_manager #(
    .NUM_ORDERS(N), .FRAMES_PER_SEC(60), .ORDER_SEC(40),
    .SPAWN_SEC(15), .BASE_POINTS(20), .MISS_PENALTY(10)
  ) dut (
    .vsync(vsync), .reset(reset), .game_state(game_state),
    .object_grid(object_grid), .clear_space(clear_space), .score(score),
    .order_active(order_active), .order_time(order_time),
    .orders_served(orders_served), .orders_missed(orders_missed),
    .win_state(win_state), .spawn_count(spawn_count)
  );

  // Clock: state changes on negedge, the bench acts on posedge.
  always #5 vsync = ~vsync;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge vsync);
  endtask

  task automatic begin_run();
    reset       = 1'b1;
    game_state  = GS_WELCOME;
    object_grid = '0;
    @(posedge vsync);
    check("rst_score",  32'(score), 32'd0);
    check("rst_active", 32'(order_active), 32'd0);
    check("rst_served", 32'(orders_served), 32'd0);
    check("rst_missed", 32'(orders_missed), 32'd0);
    check("rst_clear",  32'(clear_space), 32'd0);
    check("rst_win",    32'(win_state), 32'd0);
    reset      = 1'b0;
    game_state = GS_START;
    @(posedge vsync);
    game_state = GS_PLAY;
  endtask

  // Scoreboard: every clear_space pulse must match the next expected one.
  always @(posedge vsync) begin
    if (clear_space != 2'b00) begin
      if (exp_q.size() == 0) check("pulse_unexpected", 32'(clear_space), 32'd0);
      else check("pulse", 32'(clear_space), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Run A: spawn timing.
    begin_run();
    wait_edges(59);
    check("a_pre_spawn", 32'(order_active), 32'd0);
    wait_edges(1);
    check("a_spawn0_active", 32'(order_active), 32'd1);
    check("a_spawn0_time",   32'(order_time[0]), 32'd40);
    check("a_spawn_reload",  32'(spawn_count), 32'd14);
    wait_edges(900);
    check("a_spawn1_active", 32'(order_active), 32'd3);
    check("a_spawn1_time0",  32'(order_time[0]), 32'd25);
    check("a_spawn1_time1",  32'(order_time[1]), 32'd40);

    // Run B: single delivery, then two windows in the same cycle.
    begin_run();
    wait_edges(660);
    check("b_time30_active", 32'(order_active), 32'd1);
    check("b_time30",        32'(order_time[0]), 32'd30);
    object_grid[4][12] = 4'd4;
    exp_q.push_back(2'b01);
    wait_edges(1);
    check("b_del_clear",  32'(clear_space), 32'd1);
    check("b_del_score",  32'(score), 32'd50);
    check("b_del_served", 32'(orders_served), 32'd1);
    check("b_del_active", 32'(order_active), 32'd0);
    wait_edges(4);
    check("b_hold_clear",  32'(clear_space), 32'd0);
    check("b_hold_score",  32'(score), 32'd50);
    check("b_hold_served", 32'(orders_served), 32'd1);
    object_grid = '0;
    wait_edges(1195);
    check("b_two_active", 32'(order_active), 32'd3);
    check("b_two_time0",  32'(order_time[0]), 32'd25);
    check("b_two_time1",  32'(order_time[1]), 32'd40);
    object_grid[4][12] = 4'd4;
    object_grid[5][12] = 4'd4;
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b10);
    wait_edges(1);
    check("b_arb0_clear",  32'(clear_space), 32'd1);
    check("b_arb0_score",  32'(score), 32'd95);
    check("b_arb0_served", 32'(orders_served), 32'd2);
    wait_edges(1);
    check("b_arb1_clear",  32'(clear_space), 32'd2);
    check("b_arb1_score",  32'(score), 32'd155);
    check("b_arb1_served", 32'(orders_served), 32'd3);
    check("b_arb1_active", 32'(order_active), 32'd0);
    wait_edges(1);
    check("b_arb_done", 32'(clear_space), 32'd0);
    object_grid = '0;

    // Run C: expiry, pause freeze, reset during a pulse.
    begin_run();
    wait_edges(2459);
    check("c_pre_exp_active", 32'(order_active), 32'd7);
    check("c_pre_exp_time0",  32'(order_time[0]), 32'd1);
    wait_edges(1);
    check("c_exp_active", 32'(order_active), 32'd6);
    check("c_exp_time0",  32'(order_time[0]), 32'd0);
    check("c_exp_missed", 32'(orders_missed), 32'd1);
    check("c_exp_score",  32'(score), 32'd0);
    wait_edges(5);
    game_state = GS_PAUSE;
    object_grid[4][12] = 4'd4;
    object_grid[5][12] = 4'd4;
    wait_edges(500);
    check("c_pause_clear",  32'(clear_space), 32'd0);
    check("c_pause_active", 32'(order_active), 32'd6);
    check("c_pause_time1",  32'(order_time[1]), 32'd15);
    check("c_pause_time2",  32'(order_time[2]), 32'd30);
    check("c_pause_spawn",  32'(spawn_count), 32'd4);
    check("c_pause_score",  32'(score), 32'd0);
    check("c_pause_win",    32'(win_state), 32'd0);
    exp_q.push_back(2'b01);
    game_state = GS_PLAY;
    wait_edges(1);
    check("c_resume_clear",  32'(clear_space), 32'd1);
    check("c_resume_score",  32'(score), 32'd35);
    check("c_resume_active", 32'(order_active), 32'd4);
    #1 reset = 1'b1;
    #1;
    check("c_rst_clear",  32'(clear_space), 32'd0);
    check("c_rst_score",  32'(score), 32'd0);
    check("c_rst_active", 32'(order_active), 32'd0);
    check("c_rst_served", 32'(orders_served), 32'd0);
    wait_edges(4);
    check("c_rst_hold_clear", 32'(clear_space), 32'd0);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
